mux_out_checker: RTL and testbench
==================================

Name: mux_out_checker

Overview:
- Clocked result checker that sits directly downstream of the 4:1 select-mux pair (Verilog and VHDL implementations driven by a common stimulus).
- Each stimulus vector is announced by a one-cycle strobe. The block waits a programmable settle time, then samples both mux outputs and compares them with 4-state case-inequality.
- It keeps pass/mismatch/dropped statistics, captures the context of the first mismatch, and raises a halt request when a mismatch threshold is reached.

Parameters:
- CNT_W, 16, width of all statistic counters and of max_err.
- SETTLE, 2, number of wait cycles between the stim_valid edge and the compare edge (legal range 0..255).
- CTX_W, 6, width of the context vector {s1,s0,i3,i2,i1,i0}.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous soft clear. Same effect as rst; rst has priority.
- stim_valid  in  1  one-cycle strobe: a new stimulus vector was applied this cycle.
- ctx  in  CTX_W  stimulus context, sampled together with stim_valid.
- out_ref  in  1  Verilog mux output.
- out_dut  in  1  VHDL mux output.
- max_err  in  CNT_W  mismatch threshold for halt; 0 means never halt.
- busy  out  1  a vector is pending (WAIT or CMP state).
- compare_cnt  out  CNT_W  number of completed compares.
- mismatch_cnt  out  CNT_W  number of failed compares.
- dropped_cnt  out  CNT_W  number of vectors superseded before their compare.
- err_sticky  out  1  set on the first mismatch; cleared only by rst or clear.
- first_ctx  out  CTX_W  ctx of the first mismatch.
- first_ref  out  1  out_ref value at the first mismatch.
- first_dut  out  1  out_dut value at the first mismatch.
- first_idx  out  CNT_W  compare_cnt value at the time of the first mismatch (0-based index).
- halt  out  1  stop request; level, held until rst or clear.

Behaviour:
- Reset (rst or clear at an edge):
  - state = IDLE.
  - All counters, err_sticky, halt and busy = 0.
  - first_ctx, first_idx = 0; first_ref, first_dut = 0.
  - Settle counter = 0.
  - Reset mid-operation discards the pending vector without counting it.
- States:
  - IDLE → on stim_valid: latch ctx into ctx_q. Go to WAIT with the settle counter loaded to SETTLE, or go directly to CMP if SETTLE = 0.
  - WAIT → decrement the settle counter each cycle; on reaching 0, go to CMP.
  - CMP → one cycle. Sample out_ref/out_dut at this edge and update counters. Next state is IDLE, or HALT if the halt condition is met.
  - HALT → absorbs everything. stim_valid is ignored and no counters change. Exit only by rst or clear.
- Timing:
  - For stim_valid at edge t with no intervening strobe, the outputs are sampled at edge t+1+SETTLE.
  - Counters and first_* update at that same edge and are visible in the following cycle.
- Compare rule:
  - Mismatch iff out_ref !== out_dut (4-state); X vs X is a match, X vs 0 is a mismatch.
  - Synthesised form is 2-state inequality.
- On mismatch:
  - mismatch_cnt++.
  - If err_sticky = 0: capture first_ctx = ctx_q, first_ref, first_dut, first_idx = compare_cnt (pre-increment), then set err_sticky.
  - compare_cnt++ on every compare, pass or fail.
- Halt: enter HALT and assert halt when max_err ≠ 0 and the post-update mismatch_cnt ≥ max_err.
- stim_valid while in WAIT or CMP:
  - The pending vector is dropped (dropped_cnt++) and the new ctx is latched.
  - The settle counter reloads and the state goes to WAIT, or to CMP if SETTLE = 0.
  - A strobe that coincides with the CMP edge still lets that compare complete (counted). The new vector then starts; it is not counted as dropped.
- Counters saturate at all-ones and never wrap.
- busy = 1 in WAIT and CMP, 0 in IDLE and HALT.
- max_err is sampled live at each compare. Lowering it below mismatch_cnt takes effect at the next compare.

Test Plan:
1. SETTLE=2, pulse stim_valid with ctx=6'b01_1010, out_ref=out_dut=1 → compare 3 edges later; compare_cnt=1, mismatch_cnt=0, err_sticky=0, busy high for exactly 3 cycles.
2. 5 vectors where the 3rd has out_ref=1, out_dut=0, ctx=6'b10_0100 → mismatch_cnt=1, compare_cnt=5, first_idx=2, first_ctx=6'b10_0100, first_ref=1, first_dut=0. A later mismatch leaves first_* unchanged.
3. max_err=2, mismatches on vectors 1 and 4 → halt rises after vector 4's compare, compare_cnt=4. Further strobes leave all counters frozen. clear returns everything to 0 and IDLE.
4. SETTLE=3, second strobe 1 cycle after the first → dropped_cnt=1, compare_cnt=1, compared ctx is the second one. Strobe exactly on the CMP edge → dropped_cnt unchanged, compare_cnt=2 after the next window.
5. CNT_W=4: drive 20 mismatching vectors with max_err=0 → mismatch_cnt and compare_cnt stick at 15, halt stays 0.
6. rst asserted during WAIT → next cycle busy=0 and all counters 0. The pending vector is not compared, and no counter is incremented.

Source files
------------

// File: rtl/mux_out_checker.sv
// Result checker behind the Verilog/VHDL 4:1 mux pair: waits a settle time after each
// stimulus strobe, compares both mux outputs, keeps statistics and requests a halt.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no vector pending
// WAIT  | vector latched, settle counter running down
// CMP   | compare edge: sample outputs, update statistics
// HALT  | mismatch threshold reached; frozen until rst or clear
module mux_out_checker #(
    parameter int CNT_W  = 16,
    parameter int SETTLE = 2,
    parameter int CTX_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             stim_valid,
    input  logic [CTX_W-1:0] ctx,
    input  logic             out_ref,
    input  logic             out_dut,
    input  logic [CNT_W-1:0] max_err,
    output logic             busy,
    output logic [CNT_W-1:0] compare_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] dropped_cnt,
    output logic             err_sticky,
    output logic [CTX_W-1:0] first_ctx,
    output logic             first_ref,
    output logic             first_dut,
    output logic [CNT_W-1:0] first_idx,
    output logic             halt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CMP  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [7:0]       SETTLE_L = 8'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_nx;
    logic [7:0]       settle_cnt, settle_nx;
    logic [CTX_W-1:0] ctx_q, ctx_nx;
    logic [CNT_W-1:0] compare_nx, mismatch_nx, dropped_nx, first_idx_nx;
    logic [CTX_W-1:0] first_ctx_nx;
    logic             first_ref_nx, first_dut_nx, err_sticky_nx, halt_nx;
    logic             start;
    logic             mismatch;

    // Case-inequality so that X vs X matches in 4-state simulation; synthesis sees a plain XOR.
    assign mismatch = (out_ref !== out_dut);
    assign busy     = (state == S_WAIT) || (state == S_CMP);

    always_comb begin
        state_nx      = state;
        settle_nx     = settle_cnt;
        ctx_nx        = ctx_q;
        compare_nx    = compare_cnt;
        mismatch_nx   = mismatch_cnt;
        dropped_nx    = dropped_cnt;
        first_idx_nx  = first_idx;
        first_ctx_nx  = first_ctx;
        first_ref_nx  = first_ref;
        first_dut_nx  = first_dut;
        err_sticky_nx = err_sticky;
        halt_nx       = halt;
        start         = 1'b0;

        case (state)
            S_IDLE: begin
                start = stim_valid;
            end
            S_WAIT: begin
                if (stim_valid) begin
                    if (dropped_cnt != CNT_MAX) dropped_nx = dropped_cnt + 1'b1;
                    start = 1'b1;
                end else if (settle_cnt <= 8'd1) begin
                    settle_nx = 8'd0;
                    state_nx  = S_CMP;
                end else begin
                    settle_nx = settle_cnt - 8'd1;
                end
            end
            S_CMP: begin
                if (compare_cnt != CNT_MAX) compare_nx = compare_cnt + 1'b1;
                if (mismatch) begin
                    if (mismatch_cnt != CNT_MAX) mismatch_nx = mismatch_cnt + 1'b1;
                    if (!err_sticky) begin
                        err_sticky_nx = 1'b1;
                        first_ctx_nx  = ctx_q;
                        first_ref_nx  = out_ref;
                        first_dut_nx  = out_dut;
                        first_idx_nx  = compare_cnt;
                    end
                end
                // Threshold uses the post-update count and the live max_err.
                if ((max_err != '0) && (mismatch_nx >= max_err)) begin
                    state_nx = S_HALT;
                    halt_nx  = 1'b1;
                end else begin
                    state_nx = S_IDLE;
                    start    = stim_valid;
                end
            end
            S_HALT: begin
                state_nx = S_HALT;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (start) begin
            ctx_nx = ctx;
            if (SETTLE_L == 8'd0) begin
                settle_nx = 8'd0;
                state_nx  = S_CMP;
            end else begin
                settle_nx = SETTLE_L;
                state_nx  = S_WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state        <= S_IDLE;
            settle_cnt   <= 8'd0;
            ctx_q        <= '0;
            compare_cnt  <= '0;
            mismatch_cnt <= '0;
            dropped_cnt  <= '0;
            first_idx    <= '0;
            first_ctx    <= '0;
            first_ref    <= 1'b0;
            first_dut    <= 1'b0;
            err_sticky   <= 1'b0;
            halt         <= 1'b0;
        end else begin
            state        <= state_nx;
            settle_cnt   <= settle_nx;
            ctx_q        <= ctx_nx;
            compare_cnt  <= compare_nx;
            mismatch_cnt <= mismatch_nx;
            dropped_cnt  <= dropped_nx;
            first_idx    <= first_idx_nx;
            first_ctx    <= first_ctx_nx;
            first_ref    <= first_ref_nx;
            first_dut    <= first_dut_nx;
            err_sticky   <= err_sticky_nx;
            halt         <= halt_nx;
        end
    end

endmodule

// File: tb/tb_mux_out_checker.sv
// Directed bench for mux_out_checker: three instances (SETTLE=2, SETTLE=3, CNT_W=4/SETTLE=0)
// share one stimulus bus; each test resets and checks only the instance it targets.
module tb_mux_out_checker;

    logic        clk = 1'b0;
    logic        rst, clear, stim_valid, out_ref, out_dut;
    logic [5:0]  ctx;
    logic [15:0] max_err;

    logic        a_busy, a_err, a_fref, a_fdut, a_halt;
    logic [15:0] a_cmp, a_mis, a_drop, a_fidx;
    logic [5:0]  a_fctx;
    logic        b_busy, b_err, b_fref, b_fdut, b_halt;
    logic [15:0] b_cmp, b_mis, b_drop, b_fidx;
    logic [5:0]  b_fctx;
    logic        c_busy, c_err, c_fref, c_fdut, c_halt;
    logic [3:0]  c_cmp, c_mis, c_drop, c_fidx;
    logic [5:0]  c_fctx;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mux_out_checker #(.CNT_W(16), .SETTLE(2), .CTX_W(6)) u_a (
        .clk(clk), .rst(rst), .clear(clear), .stim_valid(stim_valid), .ctx(ctx),
        .out_ref(out_ref), .out_dut(out_dut), .max_err(max_err), .busy(a_busy),
        .compare_cnt(a_cmp), .mismatch_cnt(a_mis), .dropped_cnt(a_drop), .err_sticky(a_err),
        .first_ctx(a_fctx), .first_ref(a_fref), .first_dut(a_fdut), .first_idx(a_fidx),
        .halt(a_halt));

    mux_out_checker #(.CNT_W(16), .SETTLE(3), .CTX_W(6)) u_b (
        .clk(clk), .rst(rst), .clear(clear), .stim_valid(stim_valid), .ctx(ctx),
        .out_ref(out_ref), .out_dut(out_dut), .max_err(max_err), .busy(b_busy),
        .compare_cnt(b_cmp), .mismatch_cnt(b_mis), .dropped_cnt(b_drop), .err_sticky(b_err),
        .first_ctx(b_fctx), .first_ref(b_fref), .first_dut(b_fdut), .first_idx(b_fidx),
        .halt(b_halt));

    mux_out_checker #(.CNT_W(4), .SETTLE(0), .CTX_W(6)) u_c (
        .clk(clk), .rst(rst), .clear(clear), .stim_valid(stim_valid), .ctx(ctx),
        .out_ref(out_ref), .out_dut(out_dut), .max_err(max_err[3:0]), .busy(c_busy),
        .compare_cnt(c_cmp), .mismatch_cnt(c_mis), .dropped_cnt(c_drop), .err_sticky(c_err),
        .first_ctx(c_fctx), .first_ref(c_fref), .first_dut(c_fdut), .first_idx(c_fidx),
        .halt(c_halt));

    // Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic strobe(input logic [5:0] c, input logic r, input logic d);
        ctx = c; out_ref = r; out_dut = d; stim_valid = 1'b1;
        tick();
        stim_valid = 1'b0;
    endtask

    // Full window for the SETTLE=2 instance: strobe edge plus three edges to the compare.
    task automatic vec_a(input logic [5:0] c, input logic r, input logic d);
        strobe(c, r, d);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        stim_valid = 1'b1; ctx = 6'h3f; out_ref = 1'b1; out_dut = 1'b0;
        do_reset();
        stim_valid = 1'b0;
        tests_run++; if (a_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b exp 0", a_busy); end
        tests_run++; if ({a_cmp, a_mis, a_drop, a_fidx} !== 64'd0) begin tests_failed++; $display("FAIL reset_cnts got %0h exp 0", {a_cmp, a_mis, a_drop, a_fidx}); end
        tests_run++; if ({a_err, a_halt, a_fref, a_fdut, a_fctx} !== 10'd0) begin tests_failed++; $display("FAIL reset_flags got %0h exp 0", {a_err, a_halt, a_fref, a_fdut, a_fctx}); end
    endtask

    task automatic test_single_vector();
        max_err = 16'd0;
        do_reset();
        strobe(6'b01_1010, 1'b1, 1'b1);
        tests_run++; if (a_busy !== 1'b1) begin tests_failed++; $display("FAIL t1_busy0 got %0b exp 1", a_busy); end
        tick();
        tests_run++; if (a_busy !== 1'b1) begin tests_failed++; $display("FAIL t1_busy1 got %0b exp 1", a_busy); end
        tick();
        tests_run++; if (a_busy !== 1'b1 || a_cmp !== 16'd0) begin tests_failed++; $display("FAIL t1_busy2 got busy %0b cmp %0d exp 1/0", a_busy, a_cmp); end
        tick();
        tests_run++; if (a_busy !== 1'b0) begin tests_failed++; $display("FAIL t1_busy3 got %0b exp 0", a_busy); end
        tests_run++; if (a_cmp !== 16'd1 || a_mis !== 16'd0 || a_err !== 1'b0) begin tests_failed++; $display("FAIL t1_result got cmp %0d mis %0d err %0b exp 1/0/0", a_cmp, a_mis, a_err); end
    endtask

    task automatic test_first_capture();
        max_err = 16'd0;
        do_reset();
        vec_a(6'b00_0001, 1'b0, 1'b0);
        vec_a(6'b01_0010, 1'b1, 1'b1);
        vec_a(6'b10_0100, 1'b1, 1'b0);
        vec_a(6'b11_1000, 1'b0, 1'b0);
        vec_a(6'b00_1111, 1'b1, 1'b1);
        tests_run++; if (a_cmp !== 16'd5 || a_mis !== 16'd1) begin tests_failed++; $display("FAIL t2_cnts got cmp %0d mis %0d exp 5/1", a_cmp, a_mis); end
        tests_run++; if (a_fidx !== 16'd2 || a_fctx !== 6'b10_0100) begin tests_failed++; $display("FAIL t2_first got idx %0d ctx %b exp 2/100100", a_fidx, a_fctx); end
        tests_run++; if (a_fref !== 1'b1 || a_fdut !== 1'b0 || a_err !== 1'b1) begin tests_failed++; $display("FAIL t2_vals got ref %0b dut %0b err %0b exp 1/0/1", a_fref, a_fdut, a_err); end
        vec_a(6'b11_1111, 1'b0, 1'b1);
        tests_run++; if (a_mis !== 16'd2 || a_cmp !== 16'd6) begin tests_failed++; $display("FAIL t2_second got mis %0d cmp %0d exp 2/6", a_mis, a_cmp); end
        tests_run++; if (a_fidx !== 16'd2 || a_fctx !== 6'b10_0100 || a_fref !== 1'b1 || a_fdut !== 1'b0) begin tests_failed++; $display("FAIL t2_keep got idx %0d ctx %b ref %0b dut %0b exp 2/100100/1/0", a_fidx, a_fctx, a_fref, a_fdut); end
    endtask

    task automatic test_halt();
        max_err = 16'd2;
        do_reset();
        vec_a(6'd1, 1'b1, 1'b0);
        vec_a(6'd2, 1'b0, 1'b0);
        vec_a(6'd3, 1'b1, 1'b1);
        tests_run++; if (a_halt !== 1'b0 || a_mis !== 16'd1) begin tests_failed++; $display("FAIL t3_prehalt got halt %0b mis %0d exp 0/1", a_halt, a_mis); end
        vec_a(6'd4, 1'b0, 1'b1);
        tests_run++; if (a_halt !== 1'b1 || a_cmp !== 16'd4 || a_mis !== 16'd2 || a_busy !== 1'b0) begin tests_failed++; $display("FAIL t3_halt got halt %0b cmp %0d mis %0d busy %0b exp 1/4/2/0", a_halt, a_cmp, a_mis, a_busy); end
        vec_a(6'd5, 1'b1, 1'b0);
        strobe(6'd6, 1'b1, 1'b0);
        strobe(6'd7, 1'b1, 1'b0);
        repeat (4) tick();
        tests_run++; if (a_cmp !== 16'd4 || a_mis !== 16'd2 || a_drop !== 16'd0 || a_halt !== 1'b1) begin tests_failed++; $display("FAIL t3_frozen got cmp %0d mis %0d drop %0d halt %0b exp 4/2/0/1", a_cmp, a_mis, a_drop, a_halt); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests_run++; if (a_halt !== 1'b0 || a_cmp !== 16'd0 || a_mis !== 16'd0 || a_err !== 1'b0 || a_fidx !== 16'd0 || a_fctx !== 6'd0) begin tests_failed++; $display("FAIL t3_clear got halt %0b cmp %0d mis %0d err %0b exp all 0", a_halt, a_cmp, a_mis, a_err); end
        vec_a(6'd8, 1'b1, 1'b1);
        tests_run++; if (a_cmp !== 16'd1 || a_halt !== 1'b0) begin tests_failed++; $display("FAIL t3_resume got cmp %0d halt %0b exp 1/0", a_cmp, a_halt); end
    endtask

    task automatic test_drop();
        max_err = 16'd0;
        do_reset();
        strobe(6'b00_0001, 1'b1, 1'b0);
        strobe(6'b00_0010, 1'b1, 1'b0);
        repeat (3) tick();
        tests_run++; if (b_cmp !== 16'd0 || b_drop !== 16'd1) begin tests_failed++; $display("FAIL t4_before got cmp %0d drop %0d exp 0/1", b_cmp, b_drop); end
        tick();
        tests_run++; if (b_cmp !== 16'd1 || b_drop !== 16'd1 || b_fctx !== 6'b00_0010) begin tests_failed++; $display("FAIL t4_drop got cmp %0d drop %0d ctx %b exp 1/1/000010", b_cmp, b_drop, b_fctx); end
        strobe(6'd3, 1'b0, 1'b0);
        repeat (3) tick();
        strobe(6'd4, 1'b1, 1'b1);
        tests_run++; if (b_cmp !== 16'd2 || b_drop !== 16'd1 || b_busy !== 1'b1) begin tests_failed++; $display("FAIL t4_cmpedge got cmp %0d drop %0d busy %0b exp 2/1/1", b_cmp, b_drop, b_busy); end
        repeat (4) tick();
        tests_run++; if (b_cmp !== 16'd3 || b_drop !== 16'd1 || b_busy !== 1'b0) begin tests_failed++; $display("FAIL t4_next got cmp %0d drop %0d busy %0b exp 3/1/0", b_cmp, b_drop, b_busy); end
    endtask

    task automatic test_back_to_back();
        max_err = 16'd0;
        do_reset();
        ctx = 6'd9; out_ref = 1'b1; out_dut = 1'b0; stim_valid = 1'b1;
        repeat (15) tick();
        stim_valid = 1'b0;
        tick();
        tests_run++; if (c_cmp !== 4'd15 || c_mis !== 4'd15 || c_drop !== 4'd0) begin tests_failed++; $display("FAIL t5_fifteen got cmp %0d mis %0d drop %0d exp 15/15/0", c_cmp, c_mis, c_drop); end
        stim_valid = 1'b1;
        repeat (5) tick();
        stim_valid = 1'b0;
        tick();
        tests_run++; if (c_cmp !== 4'd15 || c_mis !== 4'd15 || c_halt !== 1'b0) begin tests_failed++; $display("FAIL t5_sat got cmp %0d mis %0d halt %0b exp 15/15/0", c_cmp, c_mis, c_halt); end
        tests_run++; if (c_fidx !== 4'd0 || c_fctx !== 6'd9 || c_drop !== 4'd0) begin tests_failed++; $display("FAIL t5_first got idx %0d ctx %0d drop %0d exp 0/9/0", c_fidx, c_fctx, c_drop); end
        max_err = 16'd15;
        strobe(6'd10, 1'b0, 1'b0);
        tick();
        tests_run++; if (c_halt !== 1'b1 || c_busy !== 1'b0) begin tests_failed++; $display("FAIL t5_live got halt %0b busy %0b exp 1/0", c_halt, c_busy); end
    endtask

    task automatic test_reset_midway();
        max_err = 16'd0;
        do_reset();
        strobe(6'd21, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++; if (a_busy !== 1'b0 || a_cmp !== 16'd0 || a_mis !== 16'd0 || a_drop !== 16'd0) begin tests_failed++; $display("FAIL t6_rst got busy %0b cmp %0d mis %0d drop %0d exp 0", a_busy, a_cmp, a_mis, a_drop); end
        repeat (5) tick();
        tests_run++; if (a_cmp !== 16'd0 || a_mis !== 16'd0 || a_err !== 1'b0 || a_busy !== 1'b0) begin tests_failed++; $display("FAIL t6_nocmp got cmp %0d mis %0d err %0b busy %0b exp 0", a_cmp, a_mis, a_err, a_busy); end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; stim_valid = 1'b0; ctx = '0;
        out_ref = 1'b0; out_dut = 1'b0; max_err = '0;
        repeat (2) tick();
        test_reset();
        test_single_vector();
        test_first_capture();
        test_halt();
        test_drop();
        test_back_to_back();
        test_reset_midway();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
